// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the branch predictor
// Contents: 2-bit counter encodings, FSM state enum, table entry struct.
package bp_pkg;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // Tag field is sized for the smallest useful index; the top pads unused
  // high tag bits with zeros so the struct does not depend on INDEX_BITS.
  localparam int TAG_W_MAX = 30;

  typedef enum logic {
    INIT,
    RUN
  } bp_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational 2-bit saturating up/down counter
// Ports:
//   ctr      in  current counter value
//   inc      in  1 = count up (taken), 0 = count down (not taken)
//   ctr_next out saturated next value
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_STRONG_T) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_STRONG_NT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-stage bimodal predictor with tagged BTB
// Optional macro: BP_UPDATE_BYPASS_EN forwards a same-cycle update into the lookup.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_valid, fetch_pc    lookup request from IF
//   pred_valid/taken/target  registered prediction, one cycle after the lookup
//   ready                    table initialised (RUN state)
//   update_valid, update_pc, update_is_jump, update_taken, update_target
//                            resolved control-flow outcome from EX
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CTR_INIT   = CTR_WEAK_NT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        ready,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_is_jump,
  input  logic        update_taken,
  input  logic [31:0] update_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  bp_entry_t entries [ENTRIES];

  bp_state_t              state, state_next;
  logic [INDEX_BITS-1:0]  sweep;

  logic [INDEX_BITS-1:0]  f_idx, u_idx;
  logic [TAG_W_MAX-1:0]   f_tag, u_tag;
  bp_entry_t              f_ent, u_ent, u_new, look;
  logic                   u_hit, u_we, look_taken;
  logic [1:0]             ctr_next;
  logic                   unused_ctr_lsb;

  // pc[1:0] never reaches index or tag; the tag is zero-extended to the
  // package field width.
  assign f_idx = fetch_pc[INDEX_BITS+1:2];
  assign u_idx = update_pc[INDEX_BITS+1:2];
  assign f_tag = TAG_W_MAX'(fetch_pc >> (INDEX_BITS + 2));
  assign u_tag = TAG_W_MAX'(update_pc >> (INDEX_BITS + 2));

  assign f_ent = entries[f_idx];
  assign u_ent = entries[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  assign ready = (state == RUN);

  // FSM: INIT sweeps every entry once, then RUN forever until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) sweep <= sweep + INDEX_BITS'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (sweep == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  bp_sat_counter u_ctr (
    .ctr      (u_ent.ctr),
    .inc      (update_taken),
    .ctr_next (ctr_next)
  );

  // Update path: jumps always (re)allocate as strongly taken; branches train
  // on a hit and allocate weakly taken only when taken on a miss.
  always_comb begin
    u_new = u_ent;
    u_we  = 1'b0;
    if (update_valid && state == RUN) begin
      if (update_is_jump) begin
        u_new = '{valid: 1'b1, tag: u_tag, target: update_target, ctr: CTR_STRONG_T};
        u_we  = 1'b1;
      end else if (u_hit) begin
        u_new.ctr = ctr_next;
        if (update_taken) u_new.target = update_target;
        u_we = 1'b1;
      end else if (update_taken) begin
        u_new = '{valid: 1'b1, tag: u_tag, target: update_target, ctr: CTR_WEAK_T};
        u_we  = 1'b1;
      end
    end
  end

  // The table is not reset directly; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        entries[sweep] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};
      end else if (u_we) begin
        entries[u_idx] <= u_new;
      end
    end
  end

  always_comb begin
    look = f_ent;
`ifdef BP_UPDATE_BYPASS_EN
    if (u_we && (u_idx == f_idx)) look = u_new;
`endif
  end

  assign look_taken     = look.valid && (look.tag == f_tag) && look.ctr[1];
  assign unused_ctr_lsb = look.ctr[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (state == RUN && fetch_valid) begin
      pred_valid  <= 1'b1;
      pred_taken  <= look_taken;
      pred_target <= look_taken ? look.target : 32'd0;
    end else begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard testbench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_valid, pred_taken, ready;
  logic [31:0] pred_target;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_is_jump = 1'b0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;

  int tests = 0;
  int fails = 0;
  logic [33:0] sb [$];

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ready          (ready),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_is_jump (update_is_jump),
    .update_taken   (update_taken),
    .update_target  (update_target)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, push the expected prediction, then compare it
  // against what the DUT registers on that edge.
  task automatic step(input string tag,
                      input logic fv, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic uj,
                      input logic ut, input logic [31:0] utgt,
                      input logic ev, input logic et, input logic [31:0] etgt);
    logic [33:0] exp;
    @(negedge clk);
    fetch_valid = fv; fetch_pc = fpc;
    update_valid = uv; update_pc = upc; update_is_jump = uj;
    update_taken = ut; update_target = utgt;
    sb.push_back({ev, et, etgt});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check(tag, {30'd0, pred_valid, pred_taken, pred_target}, {30'd0, exp});
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input logic et, input logic [31:0] etgt);
    step(tag, 1'b1, pc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, et, etgt);
  endtask

  task automatic update(input string tag, input logic [31:0] pc, input logic uj, input logic ut, input logic [31:0] tgt);
    step(tag, 1'b0, 32'd0, 1'b1, pc, uj, ut, tgt, 1'b0, 1'b0, 32'd0);
  endtask

  // Reset pulse, then hold a fetch and a jump update throughout INIT;
  // both must be ignored and ready must stay low for exactly 64 cycles.
  task automatic do_init(input string tag);
    int n;
    int bad;
    @(negedge clk);
    rst = 1'b1; fetch_valid = 1'b0; update_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rst_ready"}, 64'(ready), 64'd0);
    check({tag, "_rst_pred"}, {30'd0, pred_valid, pred_taken, pred_target}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 32'h0000_0100;
    update_valid = 1'b1; update_pc = 32'h0000_0108; update_is_jump = 1'b1;
    update_taken = 1'b1; update_target = 32'h0000_0077;
    n = 0;
    bad = 0;
    while (ready !== 1'b1 && n < 200) begin
      n++;
      if (pred_valid !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    if (pred_valid !== 1'b0) bad++;
    check({tag, "_init_cycles"}, 64'(n), 64'd64);
    check({tag, "_init_pred_valid"}, 64'(bad), 64'd0);
    check({tag, "_ready"}, 64'(ready), 64'd1);
    @(negedge clk);
    fetch_valid = 1'b0; update_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    do_init("init1");

    fetch("init_update_ignored", 32'h0000_0108, 1'b0, 32'd0);
    fetch("cold", 32'h0000_0100, 1'b0, 32'd0);

    update("train_t", 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0080);
    fetch("ctr10", 32'h0000_0100, 1'b1, 32'h0000_0080);
    update("nt1", 32'h0000_0100, 1'b0, 1'b0, 32'd0);
    fetch("ctr01", 32'h0000_0100, 1'b0, 32'd0);
    update("nt2", 32'h0000_0100, 1'b0, 1'b0, 32'd0);
    fetch("ctr00", 32'h0000_0100, 1'b0, 32'd0);
    update("nt3", 32'h0000_0100, 1'b0, 1'b0, 32'd0);
    update("t_after_sat", 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0080);
    fetch("sat_low_ctr01", 32'h0000_0100, 1'b0, 32'd0);
    update("t_to_10", 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0080);
    fetch("ctr10_again", 32'h0000_0100, 1'b1, 32'h0000_0080);
    update("t_new_tgt", 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0090);
    fetch("ctr11_tgt", 32'h0000_0100, 1'b1, 32'h0000_0090);

    fetch("alias_300", 32'h0000_0300, 1'b0, 32'd0);
    fetch("alias_200", 32'h0000_0200, 1'b0, 32'd0);

    step("collide_11", 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0,
         1'b1, 1'b1, 32'h0000_0090);
    fetch("after_collide_10", 32'h0000_0100, 1'b1, 32'h0000_0090);
`ifdef BP_UPDATE_BYPASS_EN
    step("collide_10", 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0,
         1'b1, 1'b0, 32'd0);
`else
    step("collide_10", 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0,
         1'b1, 1'b1, 32'h0000_0090);
`endif
    fetch("after_collide_01", 32'h0000_0100, 1'b0, 32'd0);

    update("jump_200", 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0400);
    fetch("jump_hit", 32'h0000_0200, 1'b1, 32'h0000_0400);
    fetch("evicted_100", 32'h0000_0100, 1'b0, 32'd0);
    update("t_sat1", 32'h0000_0200, 1'b0, 1'b1, 32'h0000_0400);
    update("t_sat2", 32'h0000_0200, 1'b0, 1'b1, 32'h0000_0400);
    update("nt_from_11", 32'h0000_0200, 1'b0, 1'b0, 32'd0);
    fetch("sat_high_ctr10", 32'h0000_0200, 1'b1, 32'h0000_0400);

    update("jump_104", 32'h0000_0104, 1'b1, 1'b1, 32'h0000_0050);
    fetch("pc_lsb_ignored", 32'h0000_0106, 1'b1, 32'h0000_0050);
    fetch("other_index_kept", 32'h0000_0200, 1'b1, 32'h0000_0400);

    do_init("init2");
    fetch("reinit_200", 32'h0000_0200, 1'b0, 32'd0);
    fetch("reinit_104", 32'h0000_0104, 1'b0, 32'd0);
    fetch("reinit_108", 32'h0000_0108, 1'b0, 32'd0);
    step("idle", 1'b0, 32'h0000_0104, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
